// File: rtl/gru_pkg.sv
// -----------------------------------------------------------------------------
// gru_pkg
// Shared definitions for the GRU timestep sequencer: default sizing constants,
// gate encodings, the sequencer state enum and a width helper.
// -----------------------------------------------------------------------------
package gru_pkg;

    // Default sizing: datapath word width, input vector length, neurons per gate.
    localparam int GRU_FIXED      = 32;
    localparam int GRU_NB_INPUTS  = 24;
    localparam int GRU_NB_NEURONS = 24;

    // Gate encodings, in processing order (all r values exist before H starts).
    localparam logic [1:0] GATE_Z = 2'd0;
    localparam logic [1:0] GATE_R = 2'd1;
    localparam logic [1:0] GATE_H = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        MAC_IN,
        MAC_REC,
        ACT,
        WR,
        UPD,
        DONE
    } gru_state_t;

    // Bit width needed to index 'value' entries, never below one bit so that
    // degenerate sizes still give legal vector declarations.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage : gru_pkg

// File: rtl/gru_addr_gen.sv
// -----------------------------------------------------------------------------
// gru_addr_gen
// Combinational address generator for the GRU parameter memories.
//
// Ports:
//   g         in   gate index (0 = Z, 1 = R, 2 = H)
//   n         in   neuron index within the gate
//   k         in   input/state vector index
//   bias_addr out  g*N + n
//   win_addr  out  k*3N + g*N + n   (input weights)
//   wrec_addr out  k*3N + g*N + n   (recurrent weights)
//
// All terms are widened to the destination width before the arithmetic, and
// every destination is sized for its largest legal address, so nothing wraps.
// -----------------------------------------------------------------------------
module gru_addr_gen
    import gru_pkg::*;
#(
    parameter  int NB_INPUTS  = GRU_NB_INPUTS,
    parameter  int NB_NEURONS = GRU_NB_NEURONS,
    localparam int NW = clog2_min1(NB_NEURONS),
    localparam int BW = clog2_min1(3 * NB_NEURONS),
    localparam int WW = clog2_min1(3 * NB_NEURONS * NB_INPUTS),
    localparam int RW = clog2_min1(3 * NB_NEURONS * NB_NEURONS),
    localparam int KW = clog2_min1((NB_INPUTS > NB_NEURONS) ? NB_INPUTS : NB_NEURONS)
) (
    input  logic [1:0]    g,
    input  logic [NW-1:0] n,
    input  logic [KW-1:0] k,
    output logic [BW-1:0] bias_addr,
    output logic [WW-1:0] win_addr,
    output logic [RW-1:0] wrec_addr
);

    always_comb begin
        bias_addr = BW'(g) * BW'(NB_NEURONS) + BW'(n);
        win_addr  = WW'(k) * WW'(3 * NB_NEURONS) + WW'(g) * WW'(NB_NEURONS) + WW'(n);
        wrec_addr = RW'(k) * RW'(3 * NB_NEURONS) + RW'(g) * RW'(NB_NEURONS) + RW'(n);
    end

endmodule : gru_addr_gen

// File: rtl/gru_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gru_seq_ctrl
// Sequencer for one GRU timestep. For each gate Z, R, H and each neuron n it
// loads the bias, accumulates M input products and N state products, requests
// an activation, writes the gate register; finally it updates the N state
// entries and pulses done.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   start          begin a timestep (honoured in IDLE only)
//   busy, done     activity flag; one-cycle completion pulse
//   gate, neuron   current gate (0 Z, 1 R, 2 H) and neuron index
//   bias_addr, win_addr, wrec_addr, vec_idx   memory / vector addresses
//   mac_load, mac_en, mac_src, mac_rmul       accumulator controls
//   act_req, act_sel, act_ack                 activation handshake
//   gate_we, st_we                            gate-register / state writes
//
// Every output is registered and decoded from the next state and next
// counters, so each address appears in the same cycle as its strobe and is
// zero whenever its strobe is low.
// -----------------------------------------------------------------------------
module gru_seq_ctrl
    import gru_pkg::*;
#(
    parameter  int FIXED      = GRU_FIXED,
    parameter  int NB_INPUTS  = GRU_NB_INPUTS,
    parameter  int NB_NEURONS = GRU_NB_NEURONS,
    localparam int NW = clog2_min1(NB_NEURONS),
    localparam int BW = clog2_min1(3 * NB_NEURONS),
    localparam int WW = clog2_min1(3 * NB_NEURONS * NB_INPUTS),
    localparam int RW = clog2_min1(3 * NB_NEURONS * NB_NEURONS),
    localparam int KW = clog2_min1((NB_INPUTS > NB_NEURONS) ? NB_INPUTS : NB_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [1:0]    gate,
    output logic [NW-1:0] neuron,
    output logic [BW-1:0] bias_addr,
    output logic [WW-1:0] win_addr,
    output logic [RW-1:0] wrec_addr,
    output logic [KW-1:0] vec_idx,
    output logic          mac_load,
    output logic          mac_en,
    output logic          mac_src,
    output logic          mac_rmul,
    output logic          act_req,
    output logic          act_sel,
    input  logic          act_ack,
    output logic          gate_we,
    output logic          st_we
);

    // FIXED only travels with the block for downstream width checks; reject
    // nonsensical sizes at elaboration.
    if (FIXED < 1 || NB_INPUTS < 1 || NB_NEURONS < 1) begin : g_bad_params
        $error("gru_seq_ctrl: FIXED, NB_INPUTS and NB_NEURONS must all be >= 1");
    end

    localparam logic [KW-1:0] K_LAST_IN  = KW'(NB_INPUTS - 1);
    localparam logic [KW-1:0] K_LAST_REC = KW'(NB_NEURONS - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(NB_NEURONS - 1);

    gru_state_t    state, state_nx;
    logic [1:0]    g, g_nx;
    logic [NW-1:0] n, n_nx;
    logic [KW-1:0] k, k_nx;

    logic [BW-1:0] bias_nx;
    logic [WW-1:0] win_nx;
    logic [RW-1:0] wrec_nx;
    logic          in_neuron_nx;

    // Addresses are formed from the next counters so that they can be
    // registered alongside the strobes decoded from the next state.
    gru_addr_gen #(
        .NB_INPUTS  (NB_INPUTS),
        .NB_NEURONS (NB_NEURONS)
    ) u_addr_gen (
        .g         (g_nx),
        .n         (n_nx),
        .k         (k_nx),
        .bias_addr (bias_nx),
        .win_addr  (win_nx),
        .wrec_addr (wrec_nx)
    );

    // Next-state and counter logic.
    always_comb begin
        // NOTE: every variable is given a default first, so no path through
        // the case leaves it unassigned and no latch is inferred.
        state_nx = state;
        g_nx     = g;
        n_nx     = n;
        k_nx     = k;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = BIAS;
                    g_nx     = GATE_Z;
                    n_nx     = '0;
                    k_nx     = '0;
                end
            end
            BIAS: begin
                state_nx = MAC_IN;
                k_nx     = '0;
            end
            MAC_IN: begin
                if (k == K_LAST_IN) begin
                    state_nx = MAC_REC;
                    k_nx     = '0;
                end else begin
                    k_nx = k + KW'(1);
                end
            end
            MAC_REC: begin
                if (k == K_LAST_REC) begin
                    state_nx = ACT;
                    k_nx     = '0;
                end else begin
                    k_nx = k + KW'(1);
                end
            end
            ACT: begin
                // act_ack is only looked at here; elsewhere it has no effect.
                if (act_ack) begin
                    state_nx = WR;
                end
            end
            WR: begin
                if (n != N_LAST) begin
                    n_nx     = n + NW'(1);
                    state_nx = BIAS;
                end else if (g != GATE_H) begin
                    n_nx     = '0;
                    g_nx     = g + 2'd1;
                    state_nx = BIAS;
                end else begin
                    n_nx     = '0;
                    state_nx = UPD;
                end
            end
            UPD: begin
                if (n == N_LAST) begin
                    n_nx     = '0;
                    state_nx = DONE;
                end else begin
                    n_nx = n + NW'(1);
                end
            end
            DONE: begin
                g_nx     = GATE_Z;
                state_nx = IDLE;
            end
            default: begin
                g_nx     = GATE_Z;
                n_nx     = '0;
                k_nx     = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // Gate and neuron are meaningful through the per-neuron phases only.
    always_comb begin
        in_neuron_nx = state_nx inside {BIAS, MAC_IN, MAC_REC, ACT, WR};
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state     <= IDLE;
            g         <= GATE_Z;
            n         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gate      <= GATE_Z;
            neuron    <= '0;
            bias_addr <= '0;
            win_addr  <= '0;
            wrec_addr <= '0;
            vec_idx   <= '0;
            mac_load  <= 1'b0;
            mac_en    <= 1'b0;
            mac_src   <= 1'b0;
            mac_rmul  <= 1'b0;
            act_req   <= 1'b0;
            act_sel   <= 1'b0;
            gate_we   <= 1'b0;
            st_we     <= 1'b0;
        end else begin
            state     <= state_nx;
            g         <= g_nx;
            n         <= n_nx;
            k         <= k_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
            gate      <= in_neuron_nx ? g_nx : GATE_Z;
            neuron    <= (in_neuron_nx || state_nx == UPD) ? n_nx : '0;
            bias_addr <= (state_nx == BIAS)    ? bias_nx : '0;
            win_addr  <= (state_nx == MAC_IN)  ? win_nx  : '0;
            wrec_addr <= (state_nx == MAC_REC) ? wrec_nx : '0;
            vec_idx   <= (state_nx inside {MAC_IN, MAC_REC}) ? k_nx : '0;
            mac_load  <= (state_nx == BIAS);
            mac_en    <= (state_nx inside {MAC_IN, MAC_REC});
            mac_src   <= (state_nx == MAC_REC);
            mac_rmul  <= (state_nx == MAC_REC) && (g_nx == GATE_H);
            act_req   <= (state_nx == ACT);
            act_sel   <= (state_nx == ACT) && (g_nx == GATE_H);
            gate_we   <= (state_nx == WR);
            st_we     <= (state_nx == UPD);
        end
    end

endmodule : gru_seq_ctrl

// File: tb/tb_gru_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gru_seq_ctrl
// Self-checking bench for gru_seq_ctrl with M = N = 24. The expected cycle
// trace is produced by nested loops over gate, neuron and vector index that
// follow the timestep's phase order directly; each loop step advances one
// clock and compares every output. A scenario table sets the activation
// latency and input noise and lists the expected totals.
// -----------------------------------------------------------------------------
module tb_gru_seq_ctrl;

    localparam int M  = 24;
    localparam int N  = 24;
    localparam int NW = $clog2(N);
    localparam int BW = $clog2(3 * N);
    localparam int WW = $clog2(3 * N * M);
    localparam int RW = $clog2(3 * N * N);
    localparam int KW = $clog2((M > N) ? M : N);

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [1:0]    gate;
        logic [NW-1:0] neuron;
        logic [BW-1:0] bias;
        logic [WW-1:0] win;
        logic [RW-1:0] wrec;
        logic [KW-1:0] vec;
        logic          mac_load;
        logic          mac_en;
        logic          mac_src;
        logic          mac_rmul;
        logic          act_req;
        logic          act_sel;
        logic          gate_we;
        logic          st_we;
    } obs_t;

    // Scenario: ack latency (-1 = random per neuron), start/ack noise outside
    // ACT, expected done cycle (0 = 3697 plus the drawn waits) and totals.
    typedef struct {
        int delay;
        bit noise;
        int exp_done;
        int exp_gwe;
        int exp_swe;
        int exp_mac;
        int exp_rmul;
    } scen_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          act_ack;
    logic          busy, done, mac_load, mac_en, mac_src, mac_rmul;
    logic          act_req, act_sel, gate_we, st_we;
    logic [1:0]    gate;
    logic [NW-1:0] neuron;
    logic [BW-1:0] bias_addr;
    logic [WW-1:0] win_addr;
    logic [RW-1:0] wrec_addr;
    logic [KW-1:0] vec_idx;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc;
    int   done_cyc;
    int   cnt_gwe, cnt_swe, cnt_mac, cnt_rmul, cnt_done;
    bit   trace_bad;
    obs_t obs;

    gru_seq_ctrl #(
        .FIXED      (32),
        .NB_INPUTS  (M),
        .NB_NEURONS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .gate      (gate),
        .neuron    (neuron),
        .bias_addr (bias_addr),
        .win_addr  (win_addr),
        .wrec_addr (wrec_addr),
        .vec_idx   (vec_idx),
        .mac_load  (mac_load),
        .mac_en    (mac_en),
        .mac_src   (mac_src),
        .mac_rmul  (mac_rmul),
        .act_req   (act_req),
        .act_sel   (act_sel),
        .act_ack   (act_ack),
        .gate_we   (gate_we),
        .st_we     (st_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned actual,
                         input longint unsigned expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                      name, actual, expected, cyc);
    endtask

    // ---- expected output records, one per phase ----------------------------
    function automatic obs_t e_idle();
        obs_t e = '0;
        return e;
    endfunction

    function automatic obs_t e_bias(int g, int n);
        obs_t e = '0;
        e.busy = 1'b1; e.gate = 2'(g); e.neuron = NW'(n);
        e.bias = BW'(g * N + n);
        e.mac_load = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_mac_in(int g, int n, int k);
        obs_t e = '0;
        e.busy = 1'b1; e.gate = 2'(g); e.neuron = NW'(n);
        e.win = WW'(k * 3 * N + g * N + n);
        e.vec = KW'(k);
        e.mac_en = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_mac_rec(int g, int n, int k);
        obs_t e = '0;
        e.busy = 1'b1; e.gate = 2'(g); e.neuron = NW'(n);
        e.wrec = RW'(k * 3 * N + g * N + n);
        e.vec = KW'(k);
        e.mac_en = 1'b1; e.mac_src = 1'b1; e.mac_rmul = (g == 2);
        return e;
    endfunction

    function automatic obs_t e_act(int g, int n);
        obs_t e = '0;
        e.busy = 1'b1; e.gate = 2'(g); e.neuron = NW'(n);
        e.act_req = 1'b1; e.act_sel = (g == 2);
        return e;
    endfunction

    function automatic obs_t e_wr(int g, int n);
        obs_t e = '0;
        e.busy = 1'b1; e.gate = 2'(g); e.neuron = NW'(n);
        e.gate_we = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_upd(int n);
        obs_t e = '0;
        e.busy = 1'b1; e.neuron = NW'(n); e.st_we = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_done();
        obs_t e = '0;
        e.busy = 1'b1; e.done = 1'b1;
        return e;
    endfunction

    // ---- clocking helpers ---------------------------------------------------
    task automatic sample();
        obs = {busy, done, gate, neuron, bias_addr, win_addr, wrec_addr, vec_idx,
               mac_load, mac_en, mac_src, mac_rmul, act_req, act_sel, gate_we, st_we};
    endtask

    // Advance one clock, sample #1 after the edge, tally strobes and compare
    // against the expected record. After the first mismatch in a run the
    // remaining trace cycles are only tallied, to keep the log readable.
    task automatic step(input obs_t e, input string ph, input int g, input int n, input int k);
        @(posedge clk);
        #1;
        cyc++;
        sample();
        if (obs.gate_we)  cnt_gwe++;
        if (obs.st_we)    cnt_swe++;
        if (obs.mac_en)   cnt_mac++;
        if (obs.mac_rmul) cnt_rmul++;
        if (obs.done) begin
            cnt_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (!trace_bad) begin
            check($sformatf("trace_%s_g%0d_n%0d_k%0d", ph, g, n, k), 64'(obs), 64'(e));
            if (obs !== e) trace_bad = 1'b1;
        end
    endtask

    // Inputs for the next edge while the DUT is not in ACT: with noise on,
    // start and act_ack toggle randomly and must have no effect.
    task automatic drive_noise(input bit noise);
        start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        act_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // ---- reference timestep ---------------------------------------------------
    // Issues start and walks the timestep phase by phase. When do_abort is set
    // the run stops in H-gate MAC_REC at n=10, k=5 with rst and start raised.
    task automatic run_model(input int fixed_delay, input bit noise, input bit do_abort,
                             output bit aborted, output int extra);
        int d;
        aborted   = 1'b0;
        extra     = 0;
        cyc       = 0;
        done_cyc  = -1;
        trace_bad = 1'b0;
        cnt_gwe = 0; cnt_swe = 0; cnt_mac = 0; cnt_rmul = 0; cnt_done = 0;
        start   = 1'b1;
        act_ack = 1'b0;
        for (int g = 0; g < 3; g++) begin
            for (int n = 0; n < N; n++) begin
                step(e_bias(g, n), "bias", g, n, 0);
                if (g == 1 && n == 5) check("bias_addr_R_n5", 64'(obs.bias), 64'd29);
                drive_noise(noise);
                for (int k = 0; k < M; k++) begin
                    step(e_mac_in(g, n, k), "mac_in", g, n, k);
                    if (g == 1 && n == 5 && k == 3) check("win_addr_R_n5_k3", 64'(obs.win), 64'd245);
                    drive_noise(noise);
                end
                for (int k = 0; k < N; k++) begin
                    step(e_mac_rec(g, n, k), "mac_rec", g, n, k);
                    if (do_abort && g == 2 && n == 10 && k == 5) begin
                        rst     = 1'b1;
                        start   = 1'b1;
                        aborted = 1'b1;
                        return;
                    end
                    drive_noise(noise);
                end
                d = (fixed_delay < 0) ? int'($urandom_range(0, 5)) : fixed_delay;
                extra += d;
                for (int w = 0; w <= d; w++) begin
                    step(e_act(g, n), "act", g, n, w);
                    start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                    act_ack = (w == d);
                end
                step(e_wr(g, n), "wr", g, n, 0);
                drive_noise(noise);
            end
        end
        for (int n = 0; n < N; n++) begin
            step(e_upd(n), "upd", 2, n, 0);
            drive_noise(noise);
        end
        step(e_done(), "done", 0, 0, 0);
        drive_noise(noise);
        step(e_idle(), "idle_after_done", 0, 0, 0);
        start   = 1'b0;
        act_ack = 1'b0;
    endtask

    // ---- main sequence ----------------------------------------------------------
    initial begin
        scen_t tbl[4];
        bit    aborted;
        int    extra;
        int    exp_done;

        tbl[0] = '{delay:  0, noise: 1'b0, exp_done: 3697, exp_gwe: 72, exp_swe: 24, exp_mac: 3456, exp_rmul: 576};
        tbl[1] = '{delay:  3, noise: 1'b0, exp_done: 3913, exp_gwe: 72, exp_swe: 24, exp_mac: 3456, exp_rmul: 576};
        tbl[2] = '{delay:  0, noise: 1'b1, exp_done: 3697, exp_gwe: 72, exp_swe: 24, exp_mac: 3456, exp_rmul: 576};
        tbl[3] = '{delay: -1, noise: 1'b1, exp_done:    0, exp_gwe: 72, exp_swe: 24, exp_mac: 3456, exp_rmul: 576};

        // Reset with start and act_ack held high: everything must stay at 0.
        cyc = 0; done_cyc = -1; trace_bad = 1'b0;
        rst = 1'b1; start = 1'b1; act_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sample();
        check("reset_outputs", 64'(obs), 64'(e_idle()));
        rst = 1'b0; start = 1'b0; act_ack = 1'b0;
        step(e_idle(), "idle_after_reset", 0, 0, 0);

        // Reset in the middle of the H gate, start coinciding with rst.
        run_model(0, 1'b0, 1'b1, aborted, extra);
        check("abort_point_reached", 64'(aborted), 64'd1);
        trace_bad = 1'b0;
        step(e_idle(), "reset_mid_h", 0, 0, 0);
        check("reset_mid_h_busy", 64'(busy), 64'd0);
        rst = 1'b0; start = 1'b0;
        step(e_idle(), "no_start_with_rst", 0, 0, 0);
        step(e_idle(), "still_idle", 0, 0, 0);

        // Scenario table; the first row also shows a clean replay from g=0, n=0.
        for (int i = 0; i < 4; i++) begin
            run_model(tbl[i].delay, tbl[i].noise, 1'b0, aborted, extra);
            exp_done = (tbl[i].exp_done == 0) ? 3697 + extra : tbl[i].exp_done;
            check($sformatf("s%0d_done_cycle", i), 64'(done_cyc), 64'(exp_done));
            check($sformatf("s%0d_done_pulses", i), 64'(cnt_done), 64'd1);
            check($sformatf("s%0d_gate_we", i), 64'(cnt_gwe), 64'(tbl[i].exp_gwe));
            check($sformatf("s%0d_st_we", i), 64'(cnt_swe), 64'(tbl[i].exp_swe));
            check($sformatf("s%0d_mac_en", i), 64'(cnt_mac), 64'(tbl[i].exp_mac));
            check($sformatf("s%0d_mac_rmul", i), 64'(cnt_rmul), 64'(tbl[i].exp_rmul));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_gru_seq_ctrl
